bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Time-multiplexed driver for a 3-digit common-segment 7-segment display.
//  - Consumes the three BCD digits from the 0-999 counter (ones, tens, hundreds).
//  - Snapshots the digits on a load strobe, then scans them round-robin.
//  - Drives one shared segment bus plus one enable per digit.
//  - Inserts a blanking gap between digit slots to avoid ghosting.
// PARAMETERS
//  WIDTH         5      digit input width; matches the counter's digit width
//  PRESCALE      50000  clk cycles per digit slot; must be >= 2
//  BLANK_CYCLES  1      cycles at the start of each slot with an=0; must be < PRESCALE
// PORTS
//  clk    in   1        clock, rising edge
//  reset  in   1        asynchronous, active-high
//  load   in   1        snapshot strobe; sampled on the rising clk edge
//  d0     in   WIDTH    ones digit
//  d1     in   WIDTH    tens digit
//  d2     in   WIDTH    hundreds digit
//  seg    out  7        segments {a,b,c,d,e,f,g}, active-high, registered
//  an     out  3        digit enables, active-high one-hot; an[0]=ones, an[2]=hundreds; registered
//  err    out  1        high while any snapshot digit is > 9; registered
// BEHAVIOUR
//  Reset (async, immediate)
//  - snap0/1/2=0, prescaler=0, state=SCAN0, seg=7'b0000000, an=3'b000, err=0.
//  Snapshot
//  - load=1 at an edge: snap0/1/2 <= d0/d1/d2. Otherwise snapshots hold.
//  - Input changes while load=0 have no effect.
//  Prescaler
//  - Counts 0..PRESCALE-1, then wraps to 0.
//  - tick=1 when prescaler==PRESCALE-1.
//  FSM
//  - States SCAN0 (ones), SCAN1 (tens), SCAN2 (hundreds).
//  - Transitions SCAN0->SCAN1->SCAN2->SCAN0, advancing on tick only.
//  Outputs (registered from current state, prescaler and snapshots)
//  - an = onehot(state) when prescaler >= BLANK_CYCLES, else 3'b000.
//  - seg = enc(snap[state]).
//  - err = (snap0>9)|(snap1>9)|(snap2>9).
//  Timing
//  - Scan period = 3*PRESCALE cycles.
//  - Each digit enable is high for PRESCALE-BLANK_CYCLES consecutive cycles per period.
//  - load to seg/err latency: 2 cycles (snapshot register, then output register).
//  - load coincident with tick: the new snapshot is shown in the next slot; no glitch
//    within a slot beyond the 2-cycle latency.
//  Encoding (enc)
//  - 0 = 1111110,  1 = 0110000,  2 = 1101101,  3 = 1111001,  4 = 0110011
//  - 5 = 1011011,  6 = 1011111,  7 = 1110000,  8 = 1111111,  9 = 1111011
//  - Any value 10..2^WIDTH-1 = 0000001 (dash).
//  Reset mid-scan
//  - All state is cleared at once.
//  - Scanning restarts at SCAN0, prescaler=0, on the first edge after reset deasserts.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//  - Hundreds slot: seg=0000000 when snap2==0.
//  - Tens slot: seg=0000000 when snap2==0 and snap1==0.
//  - Ones digit is never blanked.
//  - an timing is unchanged by blanking.
//  LEADING_ZERO_BLANK_EN undefined:
//  - All three digits are always encoded, including leading zeros.
// TESTING (PRESCALE=4, BLANK_CYCLES=1)
//  1. Assert reset, release.
//     -> seg=0, an=0, err=0 during reset.
//     -> After release, an cycles 000,001x3,000,010x3,000,100x3 with a 12-cycle period.
//  2. load=1 for one cycle with d0=7, d1=4, d2=1.
//     -> an=001: seg=1110000.
//     -> an=010: seg=0110011.
//     -> an=100: seg=0110000.
//     -> err=0.
//  3. load with d1=12.
//     -> Tens slot seg=0000001; err=1 two cycles after load.
//     -> Reload with d1=3: err=0 two cycles later; tens slot seg=1111001.
//  4. After test 2, change d0/d1/d2 to 9/9/9 with load=0 for 24 cycles.
//     -> Displayed digits stay 7/4/1.
//  5. load d0=5, d1=0, d2=0.
//     -> With macro: hundreds and tens slots seg=0000000, ones slot seg=1011011.
//     -> Without macro: hundreds and tens slots seg=1111110.
//  6. Assert reset during SCAN2, mid-slot.
//     -> an=000 and seg=0 immediately, with no clk edge needed.
//     -> After release, the first enabled digit is an=001 and the snapshot reads 0.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner_if
//   Bundles the digit-load side and the display-drive side of the 3-digit
//   7-segment scanner.
//
//   Signals
//     load         snapshot strobe (master -> slave)
//     d0, d1, d2   ones / tens / hundreds BCD digits, WIDTH bits (master -> slave)
//     seg          segments {a,b,c,d,e,f,g}, active-high (slave -> master)
//     an           one-hot digit enables, an[0]=ones (slave -> master)
//     err          a snapshot digit is > 9 (slave -> master)
//
//   Modports
//     master  drives the digits and load strobe, observes the display
//     slave   the scanner itself
// -----------------------------------------------------------------------------
interface bcd_display_scanner_if #(
    parameter int WIDTH = 5
);
    logic             load;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [6:0]       seg;
    logic [2:0]       an;
    logic             err;

    modport master (output load, d0, d1, d2, input  seg, an, err);
    modport slave  (input  load, d0, d1, d2, output seg, an, err);
endinterface

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//   Time-multiplexed driver for a 3-digit common-segment 7-segment display.
//   The three digits are snapshotted on bus.load and scanned round-robin
//   (ones, tens, hundreds), one slot of PRESCALE clocks each. The first
//   BLANK_CYCLES of every slot keep all enables low so the previous digit's
//   segments never bleed into the next digit.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    bcd_display_scanner_if.slave (load, d0..d2 in; seg, an, err out)
//
//   Parameters
//     WIDTH         digit input width
//     PRESCALE      clocks per digit slot (>= 2)
//     BLANK_CYCLES  blanked clocks at the start of each slot (< PRESCALE)
//
//   Configuration macro
//     LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked, and
//                            the tens digit too when both it and hundreds are
//                            zero. The ones digit is always shown; enable
//                            timing is unaffected.
//
//   Latency: load -> seg/err is 2 clocks (snapshot, then output register).
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
    parameter int WIDTH        = 5,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    bcd_display_scanner_if.slave       bus
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,   // ones
        SCAN1 = 2'd1,   // tens
        SCAN2 = 2'd2    // hundreds
    } state_t;

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] snap0;
    logic [WIDTH-1:0] snap1;
    logic [WIDTH-1:0] snap2;

    logic             tick;
    logic [WIDTH-1:0] cur_digit;
    logic [6:0]       seg_next;
    logic [2:0]       an_next;
    logic             err_next;

    // Seven-segment encoding {a..g}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] enc(input logic [WIDTH-1:0] v);
        logic [31:0] vv;
        vv = 32'(v);
        case (vv)
            32'd0:   enc = 7'b1111110;
            32'd1:   enc = 7'b0110000;
            32'd2:   enc = 7'b1101101;
            32'd3:   enc = 7'b1111001;
            32'd4:   enc = 7'b0110011;
            32'd5:   enc = 7'b1011011;
            32'd6:   enc = 7'b1011111;
            32'd7:   enc = 7'b1110000;
            32'd8:   enc = 7'b1111111;
            32'd9:   enc = 7'b1111011;
            default: enc = 7'b0000001;
        endcase
    endfunction

    function automatic logic over9(input logic [WIDTH-1:0] v);
        over9 = (32'(v) > 32'd9);
    endfunction

    assign tick = (prescaler == PW'(PRESCALE - 1));

    // NOTE: every variable assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_digit = snap0;
        an_next   = 3'b000;
        seg_next  = 7'b0000000;
        err_next  = over9(snap0) | over9(snap1) | over9(snap2);

        case (state)
            SCAN0:   begin cur_digit = snap0; an_next = 3'b001; end
            SCAN1:   begin cur_digit = snap1; an_next = 3'b010; end
            SCAN2:   begin cur_digit = snap2; an_next = 3'b100; end
            default: begin cur_digit = snap0; an_next = 3'b000; end
        endcase

        // Blank the enables for the opening cycles of each slot.
        if (prescaler < PW'(BLANK_CYCLES)) begin
            an_next = 3'b000;
        end

        seg_next = enc(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (state == SCAN2 && snap2 == '0) begin
            seg_next = 7'b0000000;
        end
        if (state == SCAN1 && snap2 == '0 && snap1 == '0) begin
            seg_next = 7'b0000000;
        end
`else
        // Leading zeros are encoded like any other digit.
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN0;
            prescaler <= '0;
            snap0     <= '0;
            snap1     <= '0;
            snap2     <= '0;
            bus.seg   <= 7'b0000000;
            bus.an    <= 3'b000;
            bus.err   <= 1'b0;
        end else begin
            if (bus.load) begin
                snap0 <= bus.d0;
                snap1 <= bus.d1;
                snap2 <= bus.d2;
            end

            if (tick) begin
                prescaler <= '0;
                case (state)
                    SCAN0:   state <= SCAN1;
                    SCAN1:   state <= SCAN2;
                    default: state <= SCAN0;
                endcase
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            // Outputs are registered from the current state/prescaler/snapshots.
            bus.seg <= seg_next;
            bus.an  <= an_next;
            bus.err <= err_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
//   Self-checking bench for bcd_display_scanner with PRESCALE=4,
//   BLANK_CYCLES=1 (12-cycle scan period). Digit vectors come from a table of
//   {inputs, expected segments, expected err}; each loaded vector is queued as
//   the expected display and compared over a full scan period once the
//   snapshot has propagated. Enables are checked against the expected scan
//   pattern on every sampled cycle. Honours LEADING_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

    localparam int WIDTH = 5;

    localparam logic [6:0] SEG_ZERO = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD0 = 7'b0000000;
`else
    localparam logic [6:0] LEAD0 = 7'b1111110;
`endif

    typedef struct {
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [6:0]       s0;   // expected seg in ones slot
        logic [6:0]       s1;   // expected seg in tens slot
        logic [6:0]       s2;   // expected seg in hundreds slot
        logic             e;    // expected err
    } vec_t;

    logic clk;
    logic reset;
    int   cyc;      // rising edges since reset released
    int   checks;
    int   errors;

    vec_t vecs[8];
    vec_t sb[$];

    bcd_display_scanner_if #(.WIDTH(WIDTH)) bus ();

    bcd_display_scanner #(
        .WIDTH       (WIDTH),
        .PRESCALE    (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int phase();
        return (cyc - 1) % 12;
    endfunction

    // Scan pattern after release: 000, 001 x3, 000, 010 x3, 000, 100 x3.
    function automatic logic [2:0] exp_an();
        int p;
        if (reset || cyc == 0) return 3'b000;
        p = phase();
        if (p % 4 == 0) return 3'b000;
        return 3'b001 << (p / 4);
    endfunction

    task automatic step();
        @(negedge clk);
        check("an", {5'b0, bus.an}, {5'b0, exp_an()});
    endtask

    // Align to a period boundary, then compare every enabled slot cycle.
    task automatic check_period(input vec_t v);
        bit aligned;
        logic [6:0] es;
        aligned = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (cyc > 0 && phase() == 11) begin
                aligned = 1'b1;
                break;
            end
            step();
        end
        if (!aligned) check("period_align", 8'd0, 8'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            if (exp_an() != 3'b000) begin
                case (phase() / 4)
                    0:       es = v.s0;
                    1:       es = v.s1;
                    default: es = v.s2;
                endcase
                check($sformatf("seg_slot%0d_%0d%0d%0d", phase() / 4, v.d2, v.d1, v.d0),
                      {1'b0, bus.seg}, {1'b0, es});
            end
        end
        check("err", {7'b0, bus.err}, {7'b0, v.e});
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic ld);
        bus.d0   = a;
        bus.d1   = b;
        bus.d2   = c;
        bus.load = ld;
    endtask

    task automatic apply_vector(input vec_t v);
        vec_t exp;
        drive(v.d0, v.d1, v.d2, 1'b1);
        step();
        bus.load = 1'b0;
        sb.push_back(v);
        step();
        exp = sb.pop_front();
        check_period(exp);
    endtask

    // Load and check err is still old after one edge, new after two.
    task automatic err_latency(input vec_t v, input logic old_err);
        drive(v.d0, v.d1, v.d2, 1'b1);
        step();
        bus.load = 1'b0;
        check("err_lat_1cyc", {7'b0, bus.err}, {7'b0, old_err});
        step();
        check("err_lat_2cyc", {7'b0, bus.err}, {7'b0, v.e});
        check_period(v);
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;

        vecs[0] = '{d0: 7,  d1: 4,  d2: 1, s0: 7'b1110000, s1: 7'b0110011, s2: 7'b0110000, e: 1'b0};
        vecs[1] = '{d0: 7,  d1: 12, d2: 1, s0: 7'b1110000, s1: 7'b0000001, s2: 7'b0110000, e: 1'b1};
        vecs[2] = '{d0: 7,  d1: 3,  d2: 1, s0: 7'b1110000, s1: 7'b1111001, s2: 7'b0110000, e: 1'b0};
        vecs[3] = '{d0: 5,  d1: 0,  d2: 0, s0: 7'b1011011, s1: LEAD0,      s2: LEAD0,      e: 1'b0};
        vecs[4] = '{d0: 0,  d1: 0,  d2: 0, s0: SEG_ZERO,   s1: LEAD0,      s2: LEAD0,      e: 1'b0};
        vecs[5] = '{d0: 8,  d1: 0,  d2: 2, s0: 7'b1111111, s1: SEG_ZERO,   s2: 7'b1101101, e: 1'b0};
        vecs[6] = '{d0: 31, d1: 10, d2: 9, s0: 7'b0000001, s1: 7'b0000001, s2: 7'b1111011, e: 1'b1};
        vecs[7] = '{d0: 9,  d1: 6,  d2: 0, s0: 7'b1111011, s1: 7'b1011111, s2: LEAD0,      e: 1'b0};

        // Reset: outputs cleared, then the enable pattern over two periods.
        reset = 1'b1;
        drive(0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_seg", {1'b0, bus.seg}, 8'd0);
        check("rst_an",  {5'b0, bus.an},  8'd0);
        check("rst_err", {7'b0, bus.err}, 8'd0);
        reset = 1'b0;
        repeat (24) step();

        // Basic load, then inputs change with load low: display must hold.
        apply_vector(vecs[0]);
        drive(9, 9, 9, 1'b0);
        check_period(vecs[0]);
        check_period(vecs[0]);

        // Out-of-range tens digit and recovery, with err latency.
        err_latency(vecs[1], 1'b0);
        err_latency(vecs[2], 1'b1);

        // Remaining table vectors.
        for (int i = 3; i < 8; i++) apply_vector(vecs[i]);

        // Asynchronous reset mid hundreds slot.
        found = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (phase() == 9) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) check("find_scan2", 8'd0, 8'd1);
        check("scan2_an_before_rst", {5'b0, bus.an}, 8'b0000_0100);
        #1 reset = 1'b1;
        #1;
        check("async_rst_an",  {5'b0, bus.an},  8'd0);
        check("async_rst_seg", {1'b0, bus.seg}, 8'd0);
        check("async_rst_err", {7'b0, bus.err}, 8'd0);
        repeat (2) step();
        reset = 1'b0;
        step();
        step();
        check("post_rst_an",  {5'b0, bus.an},  8'b0000_0001);
        check("post_rst_seg", {1'b0, bus.seg}, {1'b0, SEG_ZERO});
        check("post_rst_err", {7'b0, bus.err}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
